// File: rtl/pattern_detect_sched.sv
// Round-robin scheduler sharing one programmable serial pattern detector
// among NUM_CH bit-serial requesters, with per-channel history.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   req          in   per-channel request, bit_in[i] valid while req[i]
//   bit_in       in   per-channel serial data bit
//   gnt          out  one-hot combinational grant, bit consumed on req&gnt
//   cfg_load     in   load cfg_pattern at next edge, flushes histories
//   cfg_pattern  in   new pattern value (MSB = oldest bit)
//   match_valid  out  1-cycle pulse when a pattern completes
//   match_ch     out  channel of the last match (holds between matches)
//   match_count  out  saturating number of matches since reset
module pattern_detect_sched #(
  parameter int               NUM_CH  = 4,
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH-1:0]         bit_in,
  output logic [NUM_CH-1:0]         gnt,
  input  logic                      cfg_load,
  input  logic [PAT_W-1:0]          cfg_pattern,
  output logic                      match_valid,
  output logic [$clog2(NUM_CH)-1:0] match_ch,
  output logic [CNT_W-1:0]          match_count
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int FW   = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-2:0]  r_hist [NUM_CH];
  logic [FW-1:0]     r_fill [NUM_CH];
  logic [CH_W-1:0]   r_ptr;
  logic              r_mv;
  logic [CH_W-1:0]   r_mch;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_grant_en;
  logic              w_found;
  logic [CH_W-1:0]   w_g;
  logic [CH_W-1:0]   w_g_nxt;
  logic [CH_W:0]     w_sum;
  logic [CH_W-1:0]   w_idx;
  logic              w_consume;
  logic [PAT_W-1:0]  w_win;
  logic              w_hit;

  // Controller: a load always lands in FLUSH; FLUSH lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    case (r_state)
      S_RUN:   w_grant_en  = 1'b1;
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
    if (cfg_load) begin
      w_state_nxt = S_FLUSH;
      w_grant_en  = 1'b0;
    end
    if (reset) begin
      w_grant_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Rotating-priority search starting at r_ptr, wrapping modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(NUM_CH)) begin
        w_sum = w_sum - (CH_W+1)'(NUM_CH);
      end
      w_idx = w_sum[CH_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_g     = w_idx;
      end
    end
  end

  assign w_consume = w_grant_en && w_found;
  assign gnt       = w_consume ? (NUM_CH'(1) << w_g) : '0;
  assign w_g_nxt   = (w_g == CH_W'(NUM_CH - 1)) ? '0 : w_g + CH_W'(1);

  // Window is the granted channel's stored bits plus the incoming bit.
  assign w_win = {r_hist[w_g], bit_in[w_g]};
  assign w_hit = w_consume
              && (r_fill[w_g] == FILL_MAX)
              && (w_win == r_pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat <= PATTERN;
      r_ptr <= '0;
      r_mv  <= 1'b0;
      r_mch <= '0;
      r_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_hist[i] <= '0;
        r_fill[i] <= '0;
      end
    end else begin
      r_mv <= w_hit;
      if (cfg_load) begin
        r_pat <= cfg_pattern;
        for (int i = 0; i < NUM_CH; i++) begin
          r_hist[i] <= '0;
          r_fill[i] <= '0;
        end
      end else if (w_consume) begin
        r_ptr       <= w_g_nxt;
        r_hist[w_g] <= w_win[PAT_W-2:0];
        if (w_hit && !OVERLAP) begin
          r_fill[w_g] <= '0;
        end else if (r_fill[w_g] != FILL_MAX) begin
          r_fill[w_g] <= r_fill[w_g] + FW'(1);
        end
      end
      if (w_hit) begin
        r_mch <= w_g;
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign match_valid = r_mv;
  assign match_ch    = r_mch;
  assign match_count = r_cnt;

endmodule
